// File: rtl/cxapbasyncbridge_master_apb_mux_pkg.sv
// Shared definitions for the pclkm-domain APB fan-out mux:
// FSM state encoding, err_cause codes and watchdog counter width.
// Optional feature macro used by this slice: CXAPBASYNC_MUX_ERRADDR_EN.
`define CXAPBMUX_ST_IDLE   1'b0
`define CXAPBMUX_ST_ACCESS 1'b1

package cxapbasyncbridge_master_apb_mux_pkg;

    typedef enum logic {
        ST_IDLE   = `CXAPBMUX_ST_IDLE,
        ST_ACCESS = `CXAPBMUX_ST_ACCESS
    } mux_state_e;

    // err_cause codes (only meaningful with CXAPBASYNC_MUX_ERRADDR_EN)
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_SLVERR   = 2'b11;

    // access-phase watchdog counter width
    localparam int CNT_W = 16;

endpackage

`undef CXAPBMUX_ST_IDLE
`undef CXAPBMUX_ST_ACCESS

// File: rtl/cxapbasyncbridge_master_apb_mux_if.sv
// APB3 bus bundle around the fan-out mux: the upstream master bus from
// the bridge and the NUM_SLV downstream slave buses.
// master modport: the environment (bridge + slaves); slave modport: the mux.
interface cxapbasyncbridge_master_apb_mux_if #(
    parameter int NUM_SLV = 4
);
    // upstream
    logic                   pselm;
    logic                   penablem;
    logic                   pwritem;
    logic [31:0]            paddrm;
    logic [31:0]            pwdatam;
    logic [31:0]            prdatam;
    logic                   pslverrm;
    logic                   preadym;
    // downstream
    logic [NUM_SLV-1:0]     psels;
    logic                   penables;
    logic                   pwrites;
    logic [31:0]            paddrs;
    logic [31:0]            pwdatas;
    logic [32*NUM_SLV-1:0]  prdatas;
    logic [NUM_SLV-1:0]     preadys;
    logic [NUM_SLV-1:0]     pslverrs;

    modport slave (
        input  pselm, penablem, pwritem, paddrm, pwdatam,
        input  prdatas, preadys, pslverrs,
        output prdatam, pslverrm, preadym,
        output psels, penables, pwrites, paddrs, pwdatas
    );

    modport master (
        output pselm, penablem, pwritem, paddrm, pwdatam,
        output prdatas, preadys, pslverrs,
        input  prdatam, pslverrm, preadym,
        input  psels, penables, pwrites, paddrs, pwdatas
    );
endinterface

// File: rtl/cxapbasyncbridge_apb_watchdog.sv
// Access-phase watchdog: counts pclkenm-qualified ACCESS cycles with no
// slave ready and flags to_hit once TIMEOUT_CYCLES is reached. Also owns
// the sticky timeout_sts flag.
module cxapbasyncbridge_apb_watchdog
    import cxapbasyncbridge_master_apb_mux_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic pclkm,
    input  logic presetmn,
    input  logic pclkenm,
    input  logic in_access,
    input  logic slv_rdy,
    input  logic timeout_clr,
    output logic to_hit,
    output logic timeout_sts
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    // outside ACCESS the count is stale until the next IDLE clear
    assign to_hit = in_access && (cnt_q == LIMIT);

    // clear while idle, count stalled access cycles, hold at the limit
    always_ff @(posedge pclkm or negedge presetmn) begin
        if (!presetmn)
            cnt_q <= '0;
        else if (pclkenm) begin
            if (!in_access)
                cnt_q <= '0;
            else if (!slv_rdy && cnt_q != LIMIT)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // sticky flag; a firing timeout beats a simultaneous clear
    always_ff @(posedge pclkm or negedge presetmn) begin
        if (!presetmn)
            timeout_sts <= 1'b0;
        else if (pclkenm) begin
            if (to_hit && !slv_rdy)
                timeout_sts <= 1'b1;
            else if (timeout_clr)
                timeout_sts <= 1'b0;
        end
    end
endmodule

// File: rtl/cxapbasyncbridge_master_apb_mux.sv
// Fans the bridge's pclkm-domain APB3 master bus out to NUM_SLV slaves by
// decoding paddrm[ADDR_LSB +: clog2(NUM_SLV)], muxes the selected slave's
// response back, and error-terminates hung accesses via the watchdog.
// Unmapped indices complete with zero wait states and pslverrm=1.
// Optional: CXAPBASYNC_MUX_ERRADDR_EN adds err_addr/err_cause capture.
module cxapbasyncbridge_master_apb_mux
    import cxapbasyncbridge_master_apb_mux_pkg::*;
#(
    parameter int NUM_SLV        = 4,
    parameter int ADDR_LSB       = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  pclkm,
    input  logic                                  presetmn,
    input  logic                                  pclkenm,
    cxapbasyncbridge_master_apb_mux_if.slave      bus,
    input  logic                                  timeout_clr,
    output logic                                  timeout_sts
`ifdef CXAPBASYNC_MUX_ERRADDR_EN
    ,
    output logic [31:0]                           err_addr,
    output logic [1:0]                            err_cause
`endif
);
    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    mux_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_live, idx_sel;
    logic               unmapped_q, unmapped_live, unmapped_sel;
    logic               in_access, setup, resp_act;
    logic               slv_rdy, slv_err, to_hit;
    logic [31:0]        slv_rdata;
    logic [NUM_SLV-1:0] psels_d;

    assign idx_live      = bus.paddrm[ADDR_LSB +: IDX_W];
    assign unmapped_live = ({1'b0, idx_live} >= (IDX_W+1)'(NUM_SLV));
    assign in_access     = (state_q == ST_ACCESS);
    assign setup         = bus.pselm && !bus.penablem;
    assign resp_act      = in_access && bus.penablem;

    // live address decodes the setup phase, the captured index the access
    assign idx_sel       = in_access ? idx_q      : idx_live;
    assign unmapped_sel  = in_access ? unmapped_q : unmapped_live;

    // one-hot slave select
    always_comb begin
        psels_d = '0;
        for (int i = 0; i < NUM_SLV; i++)
            psels_d[i] = bus.pselm && !unmapped_sel && (idx_sel == IDX_W'(i));
    end

    assign bus.psels    = psels_d;
    assign bus.penables = bus.penablem;
    assign bus.pwrites  = bus.pwritem;
    assign bus.paddrs   = bus.paddrm;
    assign bus.pwdatas  = bus.pwdatam;

    // pick the captured slave's response; loop form keeps unmapped indices in range
    always_comb begin
        slv_rdy   = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slv_rdy   = bus.preadys[i];
                slv_err   = bus.pslverrs[i];
                slv_rdata = bus.prdatas[32*i +: 32];
            end
        end
        slv_rdy = slv_rdy && resp_act && !unmapped_q;
    end

    // a slave response in the watchdog's final cycle wins over the timeout
    assign bus.preadym  = resp_act && (slv_rdy || unmapped_q || to_hit);
    assign bus.pslverrm = resp_act && (unmapped_q || (to_hit && !slv_rdy) || (slv_rdy && slv_err));
    assign bus.prdatam  = slv_rdy ? slv_rdata : 32'h0;

    // next state: setup opens ACCESS, a response closes it, pselm low aborts
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (setup)       state_d = ST_ACCESS;
            ST_ACCESS: if (bus.preadym) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
        if (!bus.pselm)
            state_d = ST_IDLE;
    end

    // state and setup-phase decode capture
    always_ff @(posedge pclkm or negedge presetmn) begin
        if (!presetmn) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            unmapped_q <= 1'b0;
        end else if (pclkenm) begin
            state_q <= state_d;
            if (state_q == ST_IDLE && setup) begin
                idx_q      <= idx_live;
                unmapped_q <= unmapped_live;
            end
        end
    end

    cxapbasyncbridge_apb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .pclkm       (pclkm),
        .presetmn    (presetmn),
        .pclkenm     (pclkenm),
        .in_access   (in_access),
        .slv_rdy     (slv_rdy),
        .timeout_clr (timeout_clr),
        .to_hit      (to_hit),
        .timeout_sts (timeout_sts)
    );

`ifdef CXAPBASYNC_MUX_ERRADDR_EN
    // capture address and cause of every error-completed transfer
    always_ff @(posedge pclkm or negedge presetmn) begin
        if (!presetmn) begin
            err_addr  <= 32'h0;
            err_cause <= ERR_NONE;
        end else if (pclkenm && bus.preadym && bus.pslverrm) begin
            err_addr  <= bus.paddrm;
            err_cause <= unmapped_q ? ERR_UNMAPPED :
                         slv_rdy    ? ERR_SLVERR   : ERR_TIMEOUT;
        end
    end
`endif
endmodule

// File: tb/tb_cxapbasyncbridge_master_apb_mux.sv
// Scoreboard bench for the APB fan-out mux (NUM_SLV=3, TIMEOUT_CYCLES=4).
// The driver pushes the expected response of each transfer, derived from
// wait-state count, slave error and address; a negedge monitor pops and
// compares whenever the upstream handshake completes.
module tb_cxapbasyncbridge_master_apb_mux;
    localparam int NS   = 3;
    localparam int T    = 4;
    localparam int HANG = 1000;

    logic pclkm = 1'b0, presetmn = 1'b0, pclkenm = 1'b0;
    logic timeout_clr = 1'b0, timeout_sts;
`ifdef CXAPBASYNC_MUX_ERRADDR_EN
    logic [31:0] err_addr;
    logic [1:0]  err_cause;
`endif

    cxapbasyncbridge_master_apb_mux_if #(.NUM_SLV(NS)) bus();

    cxapbasyncbridge_master_apb_mux #(
        .NUM_SLV(NS), .ADDR_LSB(12), .TIMEOUT_CYCLES(T)
    ) dut (
        .pclkm       (pclkm),
        .presetmn    (presetmn),
        .pclkenm     (pclkenm),
        .bus         (bus),
        .timeout_clr (timeout_clr),
        .timeout_sts (timeout_sts)
`ifdef CXAPBASYNC_MUX_ERRADDR_EN
        ,
        .err_addr    (err_addr),
        .err_cause   (err_cause)
`endif
    );

    always #5 pclkm = ~pclkm;

    typedef struct {
        logic [31:0] addr, wdata, data, psels, ea;
        logic        wr, err, sts;
        logic [1:0]  ec;
        int          lat;
    } item_t;

    item_t       sb[$];
    item_t       pend_it;
    bit          pend = 0;
    int          acc_en = 0;
    int          checks = 0, failures = 0;
    bit          en_mode = 0;
    logic        sts_m = 1'b0;
    logic [31:0] ea_m = 32'h0;
    logic [1:0]  ec_m = 2'b00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic rand_en();
        return en_mode ? logic'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // selected slave gets the scripted response, all others random junk
    task automatic drive_slaves(input int tgt, input logic rdy, input logic serr, input logic [31:0] rd);
        for (int j = 0; j < NS; j++) begin
            if (j == tgt) begin
                bus.preadys[j]          = rdy;
                bus.pslverrs[j]         = serr;
                bus.prdatas[32*j +: 32] = rd;
            end else begin
                bus.preadys[j]          = logic'($urandom_range(0, 1));
                bus.pslverrs[j]         = logic'($urandom_range(0, 1));
                bus.prdatas[32*j +: 32] = $urandom;
            end
        end
    endtask

    // one APB transfer; the slave is ready after w enabled access cycles
    task automatic xfer(input logic [31:0] addr, input logic wr, input int w, input logic serr,
                        input logic [31:0] rd, input bit clr_hold);
        int tgt, acc, guard;
        bit unm, tmo, done, en;
        item_t it;
        tgt = int'(addr[13:12]);
        unm = (tgt >= NS);
        tmo = !unm && (w > T);
        it.addr  = addr;
        it.wr    = wr;
        it.wdata = $urandom;
        it.lat   = unm ? 0 : (tmo ? T : w);
        it.err   = unm || tmo || serr;
        it.data  = (unm || tmo) ? 32'h0 : rd;
        it.psels = unm ? 32'h0 : (32'd1 << tgt);
        if (clr_hold) sts_m = 1'b0;
        if (tmo)      sts_m = 1'b1;
        it.sts = sts_m;
        if (it.err) begin
            ea_m = addr;
            ec_m = unm ? 2'b01 : (tmo ? 2'b10 : 2'b11);
        end
        it.ea = ea_m;
        it.ec = ec_m;
        sb.push_back(it);

        bus.pselm = 1'b1; bus.penablem = 1'b0; bus.paddrm = addr;
        bus.pwritem = wr; bus.pwdatam = it.wdata; timeout_clr = clr_hold;
        do begin
            pclkenm = rand_en();
            drive_slaves(tgt, 1'b0, serr, rd);
            en = pclkenm;
            @(posedge pclkm); #1;
        end while (!en);

        bus.penablem = 1'b1;
        acc = 0; done = 0; guard = 0;
        while (!done && guard < 300) begin
            pclkenm = rand_en();
            drive_slaves(tgt, logic'(acc >= w), serr, rd);
            @(negedge pclkm);
            done = bus.preadym && pclkenm;
            en = pclkenm;
            @(posedge pclkm); #1;
            if (en) acc++;
            guard++;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL xfer_complete actual=no_ready required=ready addr=0x%08h", addr);
        end
        bus.pselm = 1'b0; bus.penablem = 1'b0; timeout_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            pclkenm = rand_en();
            drive_slaves(-1, 1'b0, 1'b0, 32'h0);
            @(posedge pclkm); #1;
        end
    endtask

    task automatic clr_pulse();
        timeout_clr = 1'b1; pclkenm = 1'b1;
        @(posedge pclkm); #1;
        timeout_clr = 1'b0;
        sts_m = 1'b0;
        @(negedge pclkm);
        chk("sts_cleared", 32'(timeout_sts), 32'(sts_m));
    endtask

    // monitor: compare on every completed upstream handshake
    always @(negedge pclkm) begin
        if (!presetmn) begin
            acc_en = 0;
            pend = 0;
        end else begin
            if (pend) begin
                chk("timeout_sts", 32'(timeout_sts), 32'(pend_it.sts));
`ifdef CXAPBASYNC_MUX_ERRADDR_EN
                chk("err_addr",  err_addr,         pend_it.ea);
                chk("err_cause", 32'(err_cause),   32'(pend_it.ec));
`endif
                pend = 0;
            end
            if (bus.pselm && bus.penablem) begin
                if (bus.preadym && pclkenm) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_resp actual=ready required=idle @%0t", $time);
                    end else begin
                        pend_it = sb.pop_front();
                        chk("prdatam",  bus.prdatam,        pend_it.data);
                        chk("pslverrm", 32'(bus.pslverrm),  32'(pend_it.err));
                        chk("psels",    32'(bus.psels),     pend_it.psels);
                        chk("latency",  32'(acc_en),        32'(pend_it.lat));
                        chk("paddrs",   bus.paddrs,         pend_it.addr);
                        chk("pwdatas",  bus.pwdatas,        pend_it.wdata);
                        chk("pwrites",  32'(bus.pwrites),   32'(pend_it.wr));
                        pend = 1;
                    end
                    acc_en = 0;
                end else if (pclkenm) begin
                    acc_en++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.pselm = 0; bus.penablem = 0; bus.pwritem = 0;
        bus.paddrm = 0; bus.pwdatam = 0;
        bus.prdatas = '0; bus.preadys = '0; bus.pslverrs = '0;
        pclkenm = 1'b1;
        repeat (3) @(posedge pclkm);
        @(negedge pclkm);
        chk("rst_psels",    32'(bus.psels),    32'h0);
        chk("rst_preadym",  32'(bus.preadym),  32'h0);
        chk("rst_pslverrm", 32'(bus.pslverrm), 32'h0);
        chk("rst_prdatam",  bus.prdatam,       32'h0);
        chk("rst_sts",      32'(timeout_sts),  32'h0);
`ifdef CXAPBASYNC_MUX_ERRADDR_EN
        chk("rst_err_addr",  err_addr,         32'h0);
        chk("rst_err_cause", 32'(err_cause),   32'h0);
`endif
        @(posedge pclkm); #1;
        presetmn = 1'b1;
        idle(2);

        // directed cases, pclkenm held high
        en_mode = 0;
        xfer(32'h0000_2010, 1'b0, 3,    1'b0, 32'hCAFE_F00D, 0); // slave 2 read, 3 waits
        xfer(32'h0000_3000, 1'b0, 0,    1'b0, 32'h1234_5678, 0); // unmapped index 3
        xfer(32'h0000_1000, 1'b0, HANG, 1'b0, 32'hDEAD_BEEF, 0); // hung slave 1
        clr_pulse();
        xfer(32'h0000_1004, 1'b0, T,    1'b0, 32'h5A5A_A5A5, 0); // ready at cnt==T
        xfer(32'h0000_0044, 1'b1, 2,    1'b1, 32'h0BAD_0BAD, 0); // slave 0 error
        xfer(32'h0000_1008, 1'b0, HANG, 1'b0, 32'h0,         1); // timeout beats held clear
        clr_pulse();

        // enable toggling during a hung access
        en_mode = 1;
        xfer(32'h0000_100C, 1'b0, HANG, 1'b0, 32'h0, 0);
        xfer(32'h0000_2000, 1'b1, 1,    1'b0, 32'h7777_0001, 0);
        en_mode = 0;

        // reset in the middle of an access
        bus.pselm = 1; bus.penablem = 0; bus.paddrm = 32'h0000_1010; pclkenm = 1;
        drive_slaves(1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        @(posedge pclkm); #1;
        bus.penablem = 1;
        @(posedge pclkm); #1;
        presetmn = 1'b0;
        sts_m = 1'b0; ea_m = 32'h0; ec_m = 2'b00;
        @(negedge pclkm);
        chk("rstmid_preadym",  32'(bus.preadym),  32'h0);
        chk("rstmid_pslverrm", 32'(bus.pslverrm), 32'h0);
        chk("rstmid_prdatam",  bus.prdatam,       32'h0);
        chk("rstmid_sts",      32'(timeout_sts),  32'h0);
        bus.pselm = 0; bus.penablem = 0;
        @(posedge pclkm); #1;
        presetmn = 1'b1;
        idle(1);

        // randomized traffic, back-to-back when the idle gap is zero
        for (int n = 0; n < 60; n++) begin
            int w;
            en_mode = ($urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 7) == 0) ? HANG : int'($urandom_range(0, T + 2));
            xfer($urandom, logic'($urandom_range(0, 1)), w, logic'($urandom_range(0, 1)),
                 $urandom, ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 9) == 0) clr_pulse();
            idle(int'($urandom_range(0, 2)));
        end

        en_mode = 0;
        idle(4);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
